// File: rtl/stat_display_pkg.sv
// stat_display_pkg: segment patterns and selection indices shared by the stat display
package stat_display_pkg;
  localparam logic [6:0] HEX_0 = 7'h40;
  localparam logic [6:0] HEX_1 = 7'h79;
  localparam logic [6:0] HEX_2 = 7'h24;
  localparam logic [6:0] HEX_3 = 7'h30;
  localparam logic [6:0] HEX_4 = 7'h19;
  localparam logic [6:0] HEX_5 = 7'h12;
  localparam logic [6:0] HEX_6 = 7'h02;
  localparam logic [6:0] HEX_7 = 7'h78;
  localparam logic [6:0] HEX_8 = 7'h00;
  localparam logic [6:0] HEX_9 = 7'h10;
  localparam logic [6:0] HEX_A = 7'h08;
  localparam logic [6:0] HEX_B = 7'h03;
  localparam logic [6:0] HEX_C = 7'h46;
  localparam logic [6:0] HEX_D = 7'h21;
  localparam logic [6:0] HEX_E = 7'h06;
  localparam logic [6:0] HEX_F = 7'h0E;
  localparam logic [15:0][6:0] HEX_SEG = {HEX_F, HEX_E, HEX_D, HEX_C, HEX_B, HEX_A, HEX_9, HEX_8,
                                          HEX_7, HEX_6, HEX_5, HEX_4, HEX_3, HEX_2, HEX_1, HEX_0};
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [1:0] SEL_TOTAL = 2'd0;
  localparam logic [1:0] SEL_COND = 2'd1;
  localparam logic [1:0] SEL_UNCOND = 2'd2;
  localparam logic [1:0] SEL_SUCC = 2'd3;
endpackage

// File: rtl/stat_display_hex7seg.sv
// hex7seg: nibble to active-low seven-segment pattern
module hex7seg
  import stat_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);
  assign pat = HEX_SEG[nib];
endmodule

// File: rtl/stat_display.sv
// stat_display: snapshots run counters and scans the selected one onto an 8-digit display
module stat_display
  import stat_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] total,
  input  logic [31:0] conditional,
  input  logic [31:0] unconditional,
  input  logic [31:0] conditional_success,
  input  logic        sel_btn,
  input  logic        freeze,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [1:0]  sel_idx
);
  logic        btn_q;
  logic [31:0] snap [4];
  logic [15:0] scan_cnt;
  logic [2:0]  dig;
  logic [31:0] value;
  logic [3:0]  nib;
  logic [6:0]  pat;
  logic        wrap;
  // selected snapshot and the nibble for the digit currently being scanned
  always_comb begin
    value = snap[sel_idx];
    nib = value[4*dig +: 4];
    wrap = scan_cnt == 16'(SCAN_DIV - 1);
  end
  hex7seg u_hex (.nib(nib), .pat(pat));
  // button edge detection and selection step
  always_ff @(posedge clk) begin
    btn_q <= rst ? 1'b0 : sel_btn;
    sel_idx <= rst ? SEL_TOTAL : (sel_btn && !btn_q) ? sel_idx + 2'd1 : sel_idx;
  end
  // counter snapshots track the live inputs unless frozen
  always_ff @(posedge clk) begin
    if (rst) snap <= '{default: '0};
    else if (!freeze) snap <= '{total, conditional, unconditional, conditional_success};
  end
  // digit scan timing
  always_ff @(posedge clk) begin
    scan_cnt <= rst ? '0 : wrap ? '0 : scan_cnt + 16'd1;
    dig <= rst ? '0 : wrap ? dig + 3'd1 : dig;
  end
  // registered display drive; decimal point marks the digit matching the selection
  always_ff @(posedge clk) begin
    seg <= rst ? SEG_BLANK : {{1'b0, sel_idx} != dig, pat};
    an <= rst ? 8'hFF : ~(8'b1 << dig);
  end
endmodule

// File: doc/stat_display.md
Name: stat_display

Overview:
- Consumer of the pipeline run-statistics counters: total cycles, conditional branches, unconditional jumps, and correctly predicted conditional branches.
- Snapshots the four 32-bit counters and lets the user pick one with a button.
- Shows the selected counter as 8 hex digits on a time-multiplexed, active-low 8-digit seven-segment display on the FPGA board.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range 2..65535; 16-bit internal counter.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  synchronous, active-high reset.
- total  input  32  total cycle count.
- conditional  input  32  conditional branch count.
- unconditional  input  32  unconditional jump count.
- conditional_success  input  32  correct conditional branch count.
- sel_btn  input  1  debounced level from the board button; each rising edge advances the selection.
- freeze  input  1  1 = hold the snapshot, 0 = track the live counters.
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
- an  output  8  active-low digit enables; bit 0 is the rightmost (least significant) digit.
- sel_idx  output  2  current selection: 0 total, 1 conditional, 2 unconditional, 3 conditional_success.

Behaviour:
- Reset (rst=1 at a clk edge):
  - sel_idx=0, snapshots=0, scan counter=0, digit index=0, btn_q=0.
  - seg=8'hFF, an=8'hFF (blank).
  - Reset mid-scan blanks the display on the next edge.
- Selection:
  - btn_q registers sel_btn each cycle.
  - Rising edge (sel_btn=1, btn_q=0) increments sel_idx modulo 4 (3 -> 0).
  - Holding the button high gives exactly one increment.
- Snapshot: four 32-bit registers.
  - freeze=0: each register loads its input every cycle (1-cycle latency).
  - freeze=1: all four hold.
  - Changing the selection while frozen shows the frozen value of the newly selected counter.
  - The freeze edge itself needs no special handling: the value loaded on the last freeze=0 edge is the one held.
- Display value = snapshot[sel_idx].
- Scan:
  - The counter runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and the digit index increments modulo 8 (7 -> 0).
  - Digit index d selects nibble value[4d+3:4d].
- Output register, updated every cycle from the current digit index and nibble:
  - an = ~(8'b1 << d).
  - seg[6:0] = hex pattern of the nibble.
  - seg[7] (dp) = 0 (lit) only when d == sel_idx; otherwise 1.
  - seg/an therefore lag the digit index and value by 1 cycle.
  - First non-blank output appears 1 cycle after rst deasserts, showing digit 0.
- Hex patterns, seg[6:0] active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Simultaneous events:
  - A button edge and a scan wrap in the same cycle both take effect.
  - The new selection reaches seg/an 2 cycles after the edge (sel_idx register, then output register).
  - rst dominates everything.
- Width rules: no arithmetic on counter data; the display wraps nothing beyond 32 bits.

Decomposition:
- Shared package/header holds:
  - the 16 hex segment constants;
  - SEG_BLANK = 8'hFF;
  - selection index constants SEL_TOTAL=0, SEL_COND=1, SEL_UNCOND=2, SEL_SUCC=3.
- One natural sub-module: hex7seg, a combinational 4-bit nibble to 7-bit active-low pattern decoder.
- Scan/selection logic, snapshots and output registers stay in stat_display.

Test Plan (SCAN_DIV=4):
1. Reset: assert rst 3 cycles mid-scan -> seg=8'hFF, an=8'hFF, sel_idx=0. Release -> after 1 cycle an=8'hFE; with total=32'h0000_0000, seg=8'h40 with dp lit (d=0=sel_idx).
2. Scan: total=32'h89AB_CDEF, freeze=0 -> every 4 cycles an steps FE,FD,FB,...,7F then back to FE. Nibbles, seg[6:0] in order: F 0E, E 06, D 21, C 46, B 03, A 08, 9 10, 8 00.
3. Selection: pulse sel_btn high for 10 cycles 4 times -> sel_idx 1,2,3,0, exactly one step per pulse. While sel_idx=2, digit 2 has dp=0 and every other digit has dp=1.
4. Freeze: conditional=5, select 1, set freeze=1, then drive conditional=9 -> digit 0 still shows 5 (seg=8'h92 on a dp-off digit, i.e. 1,12). Clear freeze -> digit 0 shows 9 (seg[6:0]=10) within the next full scan.
5. Frozen switch: freeze=1 with snapshots total=1, unconditional=7, then advance selection to 2 -> digit 0 shows 7 (seg[6:0]=78) even though the unconditional input has since changed to 3.
6. Edge collision: sel_btn rises in the cycle the scan counter wraps -> the digit advances and sel_idx increments; the dp moves to the new digit 2 cycles after the edge.
